// File: rtl/vec_skid_stage.sv
// Two-entry elastic valid/ready stage for whole vectors (DEPTH lanes x WIDTH bits).
// Every output decodes from registers, so there is no combinational path from in_* or out_ready to any output.
module vec_skid_stage #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data  [0:DEPTH-1],
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data [0:DEPTH-1],
   output logic [1:0]       count
);

   // The encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      MAIN_HOLD,
      MAIN_LOAD_IN,
      MAIN_LOAD_SKID
   } main_sel_t;

   state_t           state, state_nxt;
   main_sel_t        main_sel;
   logic             skid_load;
   logic             accept, fire;
   logic [WIDTH-1:0] main_q [0:DEPTH-1];
   logic [WIDTH-1:0] skid_q [0:DEPTH-1];

   assign in_ready  = (state != FULL);
   assign out_valid = (state != EMPTY);
   assign count     = state;
   assign out_data  = main_q;

   assign accept = in_valid & in_ready;
   assign fire   = out_valid & out_ready;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      main_sel  = MAIN_HOLD;
      skid_load = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         unique case (state)
            EMPTY: begin
               if (accept) begin
                  state_nxt = ONE;
                  main_sel  = MAIN_LOAD_IN;
               end
            end
            ONE: begin
               if (accept && fire) begin
                  main_sel = MAIN_LOAD_IN;
               end else if (accept) begin
                  state_nxt = FULL;
                  skid_load = 1'b1;
               end else if (fire) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (fire) begin
                  state_nxt = ONE;
                  main_sel  = MAIN_LOAD_SKID;
               end
            end
            default: begin
               state_nxt = EMPTY;
            end
         endcase
      end
   end

   // NOTE: the data entries are reset (not just the state) because out_data must read all zeros after reset or flush.
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            main_q[i] <= '0;
            skid_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            unique case (main_sel)
               MAIN_LOAD_IN:   main_q[i] <= in_data[i];
               MAIN_LOAD_SKID: main_q[i] <= skid_q[i];
               default:        main_q[i] <= main_q[i];
            endcase
            if (skid_load) begin
               skid_q[i] <= in_data[i];
            end
         end
      end
   end

endmodule
